uart_tx_stream: RTL and testbench
=================================

# uart_tx_stream

Byte-serial UART transmitter (8N1, LSB first) driving `USB_RS232_TXD` on the USB-serial bridge. It runs on `USER_CLK` and accepts bytes over a valid/ready handshake. The readout path uses it to send captured ADC samples and command responses to the host. It is the transmit counterpart of the UART receiver on `USB_RS232_RXD`, and uses the same bit period: 921600 baud, nominally 1085 ns per bit.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 43: `USER_CLK` cycles per bit. Value is round(40 MHz / 921600). Legal range 2..65535.

Ports:
- `USER_CLK`, in, 1: the only clock; 40 MHz.
- `USER_RESET`, in, 1: synchronous, active-high reset.
- `tx_data`, in, 8: byte to send. Sampled only on a handshake.
- `tx_valid`, in, 1: `tx_data` is valid.
- `tx_ready`, out, 1: block can accept a byte.
- `USB_RS232_TXD`, out, 1: serial line. Idle level is high.
- `tx_done`, out, 1: one-cycle pulse on the last cycle of the stop bit.

## Operation
- Handshake: a byte is accepted on any rising edge where `tx_valid && tx_ready`. `tx_data` is latched into a shift register on that edge; later changes to `tx_data` have no effect on the frame.
- `tx_ready` is high exactly when the state is IDLE. `tx_valid` may be held high for back-to-back bytes; a new byte is accepted in the first IDLE cycle.
- States:
  - IDLE: TXD=1. On handshake, go to START.
  - START: TXD=0 for D cycles, then go to DATA.
  - DATA: 8 bits, LSB first, D cycles each. A 3-bit bit index counts 0..7. After bit 7, go to PARITY if configured, otherwise STOP.
  - PARITY: see Configuration.
  - STOP: TXD=1 for D cycles, then go to IDLE.
- Baud counter:
  - Width is `$clog2(CLKS_PER_BIT)`.
  - Loads 0 on handshake. Counts 0..D-1 within each bit, and the bit ends when it reaches D-1.
  - No free-running baud tick, so the first bit is always a full D cycles.
- `USB_RS232_TXD` is driven directly from a flop; it never glitches.
- `tx_done` is asserted in the cycle where the state is STOP and the counter is at D-1.
- Reset values: state IDLE, `USB_RS232_TXD`=1, `tx_ready`=1 (the cycle after reset is sampled), `tx_done`=0, counter 0, bit index 0, shift register 0.
- Reset mid-frame: the frame is aborted and the byte is discarded. TXD is 1 starting the cycle after reset is sampled. No `tx_done` is issued for the aborted frame.
- If reset and a handshake occur on the same edge, reset wins and the byte is not accepted.
- `tx_valid` dropping mid-frame has no effect on the frame in progress.

## Timing
- Handshake at edge N: TXD falls (start bit) at N+1.
- Data bit k occupies cycles N+1+(k+1)·D through N+(k+2)·D.
- Stop bit occupies cycles N+1+9D through N+10D, with `tx_done` at N+10D.
- `tx_ready`=1 at N+10D+1.
- Sustained frame period is 10D+1 cycles, or 11D+1 with parity. With D=43 that is 431 cycles (10.775 µs).
- Latency from handshake to first line change is 1 cycle.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - After bit 7, a PARITY state drives even parity (XOR of the 8 data bits) for D cycles, then goes to STOP.
  - Frame is 11 bits; `tx_done` at N+11D.
- `UART_TX_PARITY_EN` undefined:
  - The PARITY state and its logic are absent; DATA goes straight to STOP.
  - Frame is 10 bits.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - localparams `UART_DATA_BITS`=8 and `UART_DEFAULT_CLKS_PER_BIT`=43.

  The receiver uses the same package.
- One sub-module, `uart_bit_timer`. It contains the baud counter with a synchronous restart input and a `bit_end` output. It is reusable by the receiver, with a half-bit sample option left for that side.

## Test plan
- Reset release: hold `USER_RESET` for 3 cycles, then release. Required: TXD=1, `tx_ready`=1 and `tx_done`=0 on the first cycle after release.
- Single byte 0x55, D=43: start bit at N+1. TXD then alternates 1,0,1,0,1,0,1,0 every 43 cycles. Stop bit high. `tx_done` at N+430; `tx_ready` returns at N+431.
- Back-to-back 0x00 then 0xFF with `tx_valid` held high: second handshake exactly 431 cycles after the first. Decoded bytes are 0x00 and 0xFF. Exactly 1 idle-high cycle between the two frames.
- `tx_data` change during frame: send 0xA5, change `tx_data` to 0x3C at N+100. Required: line still carries 0xA5 (LSB first 1,0,1,0,0,1,0,1).
- Mid-frame reset: assert reset at N+200 for 1 cycle. Required: TXD=1 at N+201, no `tx_done`, `tx_ready`=1 at N+201. The next byte 0x81 is transmitted correctly.
- With `UART_TX_PARITY_EN`: send 0x07 (three ones). Required: parity bit 1 at cycles N+1+9D through N+10D, stop bit after it, `tx_done` at N+11D (N+473 for D=43).

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_tx_state_t           - transmit FSM state encoding
//   UART_DATA_BITS            - data bits per frame
//   UART_DEFAULT_CLKS_PER_BIT - round(40 MHz / 921600) clocks per bit
package uart_pkg;

  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 43;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_stream_if.sv
// uart_tx_stream_if: byte stream into the UART transmitter.
//   tx_data  - byte to send, sampled on the handshake
//   tx_valid - tx_data is valid
//   tx_ready - transmitter can accept a byte
//   tx_done  - one-cycle pulse on the last cycle of the stop bit
// Modports: master (byte producer), slave (transmitter).
interface uart_tx_stream_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_valid;
  logic                      tx_ready;
  logic                      tx_done;

  modport master (output tx_data, output tx_valid, input tx_ready, input tx_done);
  modport slave  (input tx_data, input tx_valid, output tx_ready, output tx_done);

endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: baud counter shared by the UART transmitter and receiver.
//   clk, rst - clock and synchronous active-high reset
//   restart  - reload the counter (start of a frame)
//   run      - count while high; holds otherwise
//   bit_end  - high on the last cycle of a bit period
// FIRST_HALF makes the first period after restart about half a bit long,
// which lets the receiver land its samples mid-bit. The transmitter leaves it
// clear so every bit, including the first, lasts a full CLKS_PER_BIT cycles.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = uart_pkg::UART_DEFAULT_CLKS_PER_BIT,
  parameter bit          FIRST_HALF   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic run,
  output logic bit_end
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] LOAD = FIRST_HALF ? CNT_W'(CLKS_PER_BIT / 2) : '0;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= LOAD;
    end else if (run) begin
      cnt <= bit_end ? '0 : cnt + CNT_W'(1);
    end
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: 8N1 UART transmitter, LSB first, idle-high line.
//   USER_CLK      - clock (40 MHz)
//   USER_RESET    - synchronous active-high reset; aborts any frame
//   bus           - uart_tx_stream_if.slave byte stream (valid/ready, tx_done)
//   USB_RS232_TXD - serial line, driven straight from a flop
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (11-bit frame).
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic             USER_CLK,
  input  logic             USER_RESET,
  uart_tx_stream_if.slave  bus,
  output logic             USB_RS232_TXD
);

  localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  uart_tx_state_t            state, state_next;
  logic [UART_DATA_BITS-1:0] sreg, sreg_next;
  logic [IDX_W-1:0]          bit_idx, bit_idx_next;
  logic                      txd_next;
  logic                      ready;
  logic                      handshake;
  logic                      bit_end;
`ifdef UART_TX_PARITY_EN
  logic                      par;
`endif

  assign ready        = (state == IDLE);
  assign handshake    = bus.tx_valid && ready;
  assign bus.tx_ready = ready;
  assign bus.tx_done  = (state == STOP) && bit_end;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .FIRST_HALF   (1'b0)
  ) u_timer (
    .clk     (USER_CLK),
    .rst     (USER_RESET),
    .restart (handshake),
    .run     (state != IDLE),
    .bit_end (bit_end)
  );

  always_ff @(posedge USER_CLK) begin
    if (USER_RESET) begin
      state         <= IDLE;
      sreg          <= '0;
      bit_idx       <= '0;
      USB_RS232_TXD <= 1'b1;
    end else begin
      state         <= state_next;
      sreg          <= sreg_next;
      bit_idx       <= bit_idx_next;
      USB_RS232_TXD <= txd_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is taken from the byte at the handshake because the shift
  // register no longer holds all data bits once shifting starts.
  always_ff @(posedge USER_CLK) begin
    if (USER_RESET) begin
      par <= 1'b0;
    end else if (handshake) begin
      par <= ^bus.tx_data;
    end
  end
`endif

  always_comb begin
    state_next   = state;
    sreg_next    = sreg;
    bit_idx_next = bit_idx;

    case (state)
      IDLE: begin
        if (handshake) begin
          state_next   = START;
          sreg_next    = bus.tx_data;
          bit_idx_next = '0;
        end
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end) begin
          sreg_next    = {1'b0, sreg[UART_DATA_BITS-1:1]};
          bit_idx_next = bit_idx + IDX_W'(1);
          if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The line level is decoded from the next state and registered, so TXD
  // changes on the same edge as the state and never glitches.
  always_comb begin
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = sreg_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_next = par;
`endif
      default: txd_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: directed bench for uart_tx_stream with D = 43.
// Honours UART_TX_PARITY_EN (11-bit frames plus the parity scenario).
module tb_uart_tx_stream;
  import uart_pkg::*;

  localparam int D = UART_DEFAULT_CLKS_PER_BIT;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd;

  uart_tx_stream_if bus ();

  uart_tx_stream #(.CLKS_PER_BIT(D)) dut (
    .USER_CLK      (clk),
    .USER_RESET    (rst),
    .bus           (bus),
    .USB_RS232_TXD (txd)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected line levels of a frame, bit 0 = start bit.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b11, b, 1'b0};
`endif
  endfunction

  // Present a byte for exactly one handshake edge; returns in cycle N+1.
  task automatic send(input logic [7:0] b);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    step();
    bus.tx_valid = 1'b0;
  endtask

  // Observes cycles N+1 .. N+NB*D; returns in cycle N+NB*D.
  task automatic capture(input int chg_at, input logic [7:0] chg_val,
                         output logic [10:0] bits, output bit stable,
                         output int done_at, output int done_cnt,
                         output bit ready_seen);
    bits = '1; stable = 1'b1; done_at = -1; done_cnt = 0; ready_seen = 1'b0;
    for (int c = 1; c <= NB * D; c++) begin
      int j;
      j = (c - 1) / D;
      if (c == chg_at) bus.tx_data = chg_val;
      if ((c - 1) % D == 0) bits[j] = txd;
      else if (txd !== bits[j]) stable = 1'b0;
      if (bus.tx_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (bus.tx_ready !== 1'b0) ready_seen = 1'b1;
      if (c < NB * D) step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
    step(3);
    rst = 1'b0;
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL reset_txd: got %b expected 1", txd); end
    vectors++; if (bus.tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", bus.tx_ready); end
    vectors++; if (bus.tx_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.tx_done); end
    bus.tx_data = 8'hFF;
    step(5);
    vectors++; if (txd !== 1'b1 || bus.tx_ready !== 1'b1) begin miscompares++; $display("FAIL idle_no_valid: txd=%b ready=%b expected 1/1", txd, bus.tx_ready); end
  endtask

  task automatic test_single_55();
    logic [10:0] bits; bit stable, rdy; int done_at, done_cnt;
    send(8'h55);
    capture(0, 8'h00, bits, stable, done_at, done_cnt, rdy);
    vectors++; if (bits !== frame_of(8'h55)) begin miscompares++; $display("FAIL s55_bits: got %b expected %b", bits, frame_of(8'h55)); end
    vectors++; if (stable !== 1'b1) begin miscompares++; $display("FAIL s55_bit_width: line changed inside a bit, got %b expected 1", stable); end
    vectors++; if (done_at != NB * D) begin miscompares++; $display("FAIL s55_done_at: got N+%0d expected N+%0d", done_at, NB * D); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL s55_done_cnt: got %0d expected 1", done_cnt); end
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL s55_ready_busy: got %b expected 0", rdy); end
    step();
    vectors++; if (bus.tx_ready !== 1'b1 || txd !== 1'b1) begin miscompares++; $display("FAIL s55_ready_back: ready=%b txd=%b expected 1/1", bus.tx_ready, txd); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] b1, b2; bit s1, s2, r1, r2; int d1, d2, c1, c2;
    bus.tx_data = 8'h00; bus.tx_valid = 1'b1;
    step();
    bus.tx_data = 8'hFF;
    capture(0, 8'h00, b1, s1, d1, c1, r1);
    step();
    vectors++; if (bus.tx_ready !== 1'b1 || txd !== 1'b1) begin miscompares++; $display("FAIL b2b_gap: ready=%b txd=%b expected 1/1", bus.tx_ready, txd); end
    step();
    bus.tx_valid = 1'b0;
    vectors++; if (txd !== 1'b0) begin miscompares++; $display("FAIL b2b_second_start: got %b expected 0", txd); end
    capture(0, 8'h00, b2, s2, d2, c2, r2);
    vectors++; if (b1 !== frame_of(8'h00) || s1 !== 1'b1) begin miscompares++; $display("FAIL b2b_frame1: got %b stable %b expected %b", b1, s1, frame_of(8'h00)); end
    vectors++; if (b2 !== frame_of(8'hFF) || s2 !== 1'b1) begin miscompares++; $display("FAIL b2b_frame2: got %b stable %b expected %b", b2, s2, frame_of(8'hFF)); end
    vectors++; if (d1 != NB * D || d2 != NB * D) begin miscompares++; $display("FAIL b2b_done_at: got %0d/%0d expected %0d", d1, d2, NB * D); end
    step();
    vectors++; if (bus.tx_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_back: got %b expected 1", bus.tx_ready); end
  endtask

  task automatic test_data_change();
    logic [10:0] bits; bit stable, rdy; int done_at, done_cnt;
    send(8'hA5);
    capture(100, 8'h3C, bits, stable, done_at, done_cnt, rdy);
    vectors++; if (bits !== frame_of(8'hA5)) begin miscompares++; $display("FAIL chg_bits: got %b expected %b", bits, frame_of(8'hA5)); end
    vectors++; if (stable !== 1'b1 || done_at != NB * D) begin miscompares++; $display("FAIL chg_timing: stable %b done N+%0d expected 1 and N+%0d", stable, done_at, NB * D); end
    step();
  endtask

  task automatic test_mid_reset();
    logic [10:0] bits; bit stable, rdy, d_seen; int done_at, done_cnt;
    d_seen = 1'b0;
    send(8'hC3);
    for (int c = 1; c < 200; c++) begin
      if (bus.tx_done === 1'b1) d_seen = 1'b1;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL mrst_txd: got %b expected 1", txd); end
    vectors++; if (bus.tx_ready !== 1'b1) begin miscompares++; $display("FAIL mrst_ready: got %b expected 1", bus.tx_ready); end
    vectors++; if (bus.tx_done !== 1'b0 || d_seen !== 1'b0) begin miscompares++; $display("FAIL mrst_done: got %b/%b expected 0/0", bus.tx_done, d_seen); end
    send(8'h81);
    capture(0, 8'h00, bits, stable, done_at, done_cnt, rdy);
    vectors++; if (bits !== frame_of(8'h81) || stable !== 1'b1) begin miscompares++; $display("FAIL mrst_next_bits: got %b stable %b expected %b", bits, stable, frame_of(8'h81)); end
    vectors++; if (done_at != NB * D || done_cnt != 1) begin miscompares++; $display("FAIL mrst_next_done: got N+%0d x%0d expected N+%0d x1", done_at, done_cnt, NB * D); end
    step();
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [10:0] bits; bit stable, rdy; int done_at, done_cnt;
    send(8'h07);
    capture(0, 8'h00, bits, stable, done_at, done_cnt, rdy);
    vectors++; if (bits[9] !== 1'b1) begin miscompares++; $display("FAIL par_bit: got %b expected 1", bits[9]); end
    vectors++; if (bits !== 11'b11_0000_0111_0 || stable !== 1'b1) begin miscompares++; $display("FAIL par_frame: got %b stable %b expected 11000001110", bits, stable); end
    vectors++; if (done_at != 11 * D) begin miscompares++; $display("FAIL par_done_at: got N+%0d expected N+%0d", done_at, 11 * D); end
    step();
  endtask
`endif

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    test_reset();
    test_single_55();
    test_back_to_back();
    test_data_change();
    test_mid_reset();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
